tt_bin_clock_disp: RTL and testbench

Multiplexed 6-digit 7-segment display driver for the binary clock. It reads the binary hour, minute and seconds values and converts each to two BCD digits. It then scans the six digits on a shared segment bus with a blanking slot between digits. Inputs are snapshotted once per frame so a displayed frame never mixes two different times.

---
 rtl/tt_bin_clock_disp.sv | 137 +++++++++++++
 tb/tb_tt_bin_clock_disp.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tt_bin_clock_disp.sv
// Six-digit multiplexed 7-segment driver for the binary clock. Optional macro DISP_LZ_BLANK_EN
// blanks the hour-tens digit when it is zero.
module tt_bin_clock_disp #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [3:0] hour_in,
    input  logic [5:0] minute_in,
    input  logic [5:0] seconds_in,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [5:0] dig_o,
    output logic       frame_o
);

    localparam logic [7:0] CntMax = 8'(SCAN_DIV - 1);

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] base;
        base = {2'b00, tens_of(v)} * 6'd10;
        return 4'(v - base);
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        unique case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // cnt_q/slot_q name the scan position that the next edge presents on the outputs.
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] slot_q, slot_d;
    logic [3:0] hour_q;
    logic [5:0] minute_q, seconds_q;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [5:0] dig_q, dig_d;
    logic       frame_q, frame_d;
    logic       frame_start;
    logic [3:0] digit;

    assign frame_start = (cnt_q == 8'd0) && (slot_q == 3'd0);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q     <= 8'd0;
            slot_q    <= 3'd0;
            hour_q    <= 4'd0;
            minute_q  <= 6'd0;
            seconds_q <= 6'd0;
            seg_q     <= 7'd0;
            dp_q      <= 1'b0;
            dig_q     <= 6'd0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
            if (frame_start) begin
                hour_q    <= hour_in;
                minute_q  <= minute_in;
                seconds_q <= seconds_in;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q + 8'd1;
        slot_d = slot_q;
        if (cnt_q >= CntMax) begin
            cnt_d  = 8'd0;
            slot_d = (slot_q >= 3'd5) ? 3'd0 : slot_q + 3'd1;
        end
    end

    always_comb begin
        digit = 4'd0;
        unique case (slot_q)
            3'd0:    digit = tens_of({2'b00, hour_q});
            3'd1:    digit = ones_of({2'b00, hour_q});
            3'd2:    digit = tens_of(minute_q);
            3'd3:    digit = ones_of(minute_q);
            3'd4:    digit = tens_of(seconds_q);
            3'd5:    digit = ones_of(seconds_q);
            default: digit = 4'd0;
        endcase
    end

    // During the frame-start slot the snapshot is still loading, but that cycle is blank anyway.
    always_comb begin
        seg_d   = 7'd0;
        dp_d    = 1'b0;
        dig_d   = 6'd0;
        frame_d = frame_start;
        if (cnt_q != 8'd0) begin
            dig_d = 6'b100000 >> slot_q;
            seg_d = seg_enc(digit);
            dp_d  = (slot_q == 3'd1) || (slot_q == 3'd3);
`ifdef DISP_LZ_BLANK_EN
            if ((slot_q == 3'd0) && (digit == 4'd0)) begin
                seg_d = 7'd0;
            end
`else
`endif
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign dig_o   = dig_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_tt_bin_clock_disp.sv
// Self-checking bench for tt_bin_clock_disp: directed scenarios plus random inputs,
// compared each cycle against a position-in-frame decimal reference model.
module tb_tt_bin_clock_disp;

    localparam int SD    = 4;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       reset_ni;
    logic [3:0] hour_in;
    logic [5:0] minute_in;
    logic [5:0] seconds_in;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [5:0] dig_o;
    logic       frame_o;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    int sh = 0, sm = 0, ss = 0;
    logic [6:0] seg_tbl [10];

    tt_bin_clock_disp #(.SCAN_DIV(SD)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .hour_in    (hour_in),
        .minute_in  (minute_in),
        .seconds_in (seconds_in),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .dig_o      (dig_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    // Expected {frame, dp, dig, seg} for output position p within a frame.
    function automatic logic [14:0] model(input int p);
        int slot, d;
        int vals [6];
        logic [6:0] seg;
        slot = p / SD;
        if (p % SD == 0) return (p == 0) ? 15'h4000 : 15'h0000;
        vals = '{sh / 10, sh % 10, sm / 10, sm % 10, ss / 10, ss % 10};
        d = vals[slot];
        seg = seg_tbl[d];
`ifdef DISP_LZ_BLANK_EN
        if (slot == 0 && d == 0) seg = 7'h00;
`endif
        return {1'b0, (slot == 1 || slot == 3), 6'(1 << (5 - slot)), seg};
    endfunction

    task automatic check(input string tag, input logic [14:0] exp);
        vectors++;
        assert ({frame_o, dp_o, dig_o, seg_o} === exp)
        else begin
            miscompares++;
            $error("FAIL %s n=%0d got={f,dp,dig,seg}=%h exp=%h", tag, n,
                   {frame_o, dp_o, dig_o, seg_o}, exp);
        end
    endtask

    task automatic step(input string tag);
        int p;
        @(posedge clk);
        p = n % FRAME;
        if (p == 0) begin
            sh = int'(hour_in);
            sm = int'(minute_in);
            ss = int'(seconds_in);
        end
        n++;
        #1;
        check(tag, model(p));
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour_in    = 4'(h);
        minute_in  = 6'(m);
        seconds_in = 6'(s);
    endtask

    task automatic to_frame(input string tag);
        while (n % FRAME != 0) step(tag);
    endtask

    task automatic reset_pulse(input string tag);
        #2 reset_ni = 1'b0;
        #1 check(tag, 15'h0000);
        @(negedge clk);
        reset_ni = 1'b1;
        n = 0;
    endtask

    initial begin
        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        reset_ni = 1'b0;
        set_time(12, 34, 56);
        #3 check("reset_async", 15'h0000);
        repeat (3) begin
            @(posedge clk);
            #1 check("reset_held", 15'h0000);
        end
        @(negedge clk);
        reset_ni = 1'b1;

        // Normal frame 12:34:56, two full frames.
        repeat (2 * FRAME) step("normal");

        // Snapshot coherence: change inputs at slot 2, cnt 2.
        set_time(1, 59, 59);
        to_frame("coh_align");
        repeat (FRAME) step("coh_old");
        repeat (2 * SD + 3) step("coh_pre");
        set_time(2, 0, 0);
        to_frame("coh_rest");
        repeat (FRAME) step("coh_new");

        // Out-of-range values shown literally.
        set_time(13, 63, 60);
        to_frame("oor_align");
        repeat (FRAME) step("oor");

        // Reset mid-frame during slot 3 with new inputs.
        repeat (3 * SD + 2) step("mid_pre");
        set_time(7, 8, 9);
        reset_pulse("mid_reset");
        repeat (FRAME + 2) step("mid_post");

        // Leading-zero hour.
        set_time(5, 0, 1);
        to_frame("lz_align");
        repeat (FRAME) step("lz");

        // Random inputs changed at arbitrary points, with occasional resets.
        for (int i = 0; i < 40; i++) begin
            set_time($urandom_range(15), $urandom_range(63), $urandom_range(63));
            if ($urandom_range(7) == 0) reset_pulse("rnd_reset");
            repeat ($urandom_range(40, 1)) step("random");
        end
        to_frame("rnd_tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
